ecall_io_handler: RTL and testbench

Services the environment-call requests flagged by the ECALL detector and returns the handshake `finish` that releases it. On an asserted `ecall` it decodes the service number in a7, drives the output display or samples the switches, waits for a debounced confirm-button press, writes the result back to a0, and holds `finish` long enough for the detector to clear `ecall`. It sits between the ECALL detector, the register file write port, and the board I/O.

---
 rtl/ecall_io_handler.sv | 140 ++++++++++++++
 tb/tb_ecall_io_handler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecall_io_handler.sv
// ecall_io_handler: services ECALL requests (print/read/exit) against board I/O.
// Ports: clk, rst_n, ecall, a7, a0, sw, btn_confirm -> finish, wb_en, wb_data, display, waiting, halted.
module ecall_io_handler #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int FINISH_CYCLES   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ecall,
  input  logic [31:0] a7,
  input  logic [31:0] a0,
  input  logic [15:0] sw,
  input  logic        btn_confirm,
  output logic        finish,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [31:0] display,
  output logic        waiting,
  output logic        halted
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(FINISH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WB,
    S_FIN,
    S_REARM,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_fcnt;
  logic [31:0]   r_a7;
  logic          w_press;
  logic          w_ld_a7;
  logic          w_ld_disp;
  logic          w_ld_wb;

  // Counter only runs while the synced level disagrees with the
  // debounced one, so any bounce back restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_confirm;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Edge-only press: a button already held never re-triggers.
  assign w_press = r_db & ~r_db_q;

  always_comb begin
    w_next    = r_state;
    w_ld_a7   = 1'b0;
    w_ld_disp = 1'b0;
    w_ld_wb   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ecall) begin
          w_ld_a7 = 1'b1;
          unique case (1'b1)
            (a7 == 32'd1): begin
              w_ld_disp = 1'b1;
              w_next    = S_WAIT;
            end
            (a7 == 32'd5):  w_next = S_WAIT;
            (a7 == 32'd10): w_next = S_HALT;
            default:        w_next = S_FIN;
          endcase
        end
      end
      S_WAIT: begin
        if (w_press) begin
          if (r_a7 == 32'd5) begin
            w_ld_wb = 1'b1;
            w_next  = S_WB;
          end else begin
            w_next = S_FIN;
          end
        end
      end
      S_WB:  w_next = S_FIN;
      S_FIN: begin
        if (r_fcnt == FW'(FINISH_CYCLES - 1)) w_next = S_REARM;
      end
      // Wait for the detector to drop ecall so one call is served once.
      S_REARM: begin
        if (!ecall) w_next = S_IDLE;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
      r_a7    <= '0;
      display <= '0;
      wb_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FIN) r_fcnt <= r_fcnt + 1'b1;
      else                  r_fcnt <= '0;
      if (w_ld_a7)   r_a7    <= a7;
      if (w_ld_disp) display <= a0;
      if (w_ld_wb)   wb_data <= {{16{sw[15]}}, sw};
    end
  end

  assign finish  = (r_state == S_FIN);
  assign wb_en   = (r_state == S_WB);
  assign waiting = (r_state == S_WAIT);
  assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_ecall_io_handler.sv
// tb_ecall_io_handler: directed + randomized checks of ecall_io_handler
// with DEBOUNCE_CYCLES=4, FINISH_CYCLES=3.
module tb_ecall_io_handler;

  localparam int DEB = 4;
  localparam int FIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ecall = 1'b0;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;
  logic [15:0] sw = '0;
  logic        btn = 1'b0;
  logic        finish;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [31:0] display;
  logic        waiting;
  logic        halted;

  ecall_io_handler #(
    .DEBOUNCE_CYCLES(DEB),
    .FINISH_CYCLES  (FIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ecall      (ecall),
    .a7         (a7),
    .a0         (a0),
    .sw         (sw),
    .btn_confirm(btn),
    .finish     (finish),
    .wb_en      (wb_en),
    .wb_data    (wb_data),
    .display    (display),
    .waiting    (waiting),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int fin_cyc, runs, run_len, last_len, wb_cnt, overlap;
  int first_fin, wb_at;
  logic [31:0] wb_val;
  logic fin_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (finish) begin
      fin_cyc++;
      if (!fin_prev) begin
        runs++;
        run_len = 0;
        first_fin = cyc;
      end
      run_len++;
    end else if (fin_prev) begin
      last_len = run_len;
    end
    if (wb_en) begin
      wb_cnt++;
      wb_val = wb_data;
      wb_at  = cyc;
    end
    if (wb_en && finish) overlap++;
    fin_prev = finish;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    fin_cyc = 0; runs = 0; run_len = 0; last_len = 0;
    wb_cnt = 0; overlap = 0; first_fin = -1; wb_at = -100;
    wb_val = '0;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (16) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  // Reference: what a single call should do, from the service rules.
  logic [31:0] exp_disp;

  task automatic do_call(input logic [31:0] s, input logic [31:0] arg,
                         input logic [15:0] swv, input bit drop);
    logic signed [15:0] ss;
    logic signed [31:0] sx;
    bit waits, rd;
    ss = swv;
    sx = ss;
    waits = (s == 1) || (s == 5);
    rd = (s == 5);
    if (s == 1) exp_disp = arg;
    clr();
    a7 = s; a0 = arg; sw = swv; ecall = 1'b1;
    tick();
    if (waits) begin
      chk("waiting", {31'd0, waiting}, 32'd1);
      chk("disp_in_wait", display, exp_disp);
      a7 = $urandom; a0 = $urandom;
      if (drop) ecall = 1'b0;
      repeat (3) tick();
      chk("no_fin_before_press", fin_cyc, 0);
      press();
      chk("wb_cnt", wb_cnt, rd ? 1 : 0);
      if (rd) begin
        chk("wb_data", wb_val, sx);
        chk("wb_then_fin", first_fin - wb_at, 1);
      end
      chk("overlap", overlap, 0);
    end else begin
      chk("fin_c1", {31'd0, finish}, 32'd1);
      tick();
      chk("fin_c2", {31'd0, finish}, 32'd1);
      tick();
      chk("fin_c3", {31'd0, finish}, 32'd1);
      tick();
      chk("fin_c4", {31'd0, finish}, 32'd0);
      repeat (10) tick();
    end
    chk("runs", runs, 1);
    chk("fin_len", last_len, FIN);
    chk("display", display, exp_disp);
    chk("waiting_end", {31'd0, waiting}, 32'd0);
    ecall = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    logic [31:0] s;
    exp_disp = '0;
    clr();
    repeat (3) tick();
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_disp", display, 32'd0);
    chk("rst_wb", wb_data, 32'd0);
    rst_n = 1'b1;
    tick();

    a7 = 32'd1; a0 = 32'h55; ecall = 1'b1;
    repeat (3) tick();
    chk("pre_rst_wait", {31'd0, waiting}, 32'd1);
    chk("pre_rst_disp", display, 32'h55);
    rst_n = 1'b0;
    ecall = 1'b0;
    #1;
    chk("arst_bus", {finish, wb_en, waiting, halted}, 32'd0);
    chk("arst_disp", display, 32'd0);
    chk("arst_wbd", wb_data, 32'd0);
    tick();
    rst_n = 1'b1;
    clr();
    tick();
    press();
    chk("press_after_rst", fin_cyc, 0);
    chk("disp_after_rst", display, 32'd0);

    do_call(32'd1, 32'h2A, 16'h0000, 1'b0);
    do_call(32'd5, 32'h0, 16'h8001, 1'b0);
    do_call(32'd5, 32'h0, 16'h0005, 1'b1);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(2))
        0: s = 32'd1;
        1: s = 32'd5;
        default: begin
          s = $urandom;
          if (s == 1 || s == 5 || s == 10) s = 32'd7;
        end
      endcase
      do_call(s, $urandom, 16'($urandom), 1'($urandom_range(1)));
    end

    clr();
    a7 = 32'd5; sw = 16'h1234; ecall = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (2) tick();
    end
    chk("bounce_none", wb_cnt, 0);
    btn = 1'b1;
    repeat (20) tick();
    btn = 1'b0;
    repeat (10) tick();
    chk("bounce_one_wb", wb_cnt, 1);
    chk("bounce_one_run", runs, 1);
    chk("bounce_wbd", wb_val, 32'h0000_1234);
    ecall = 1'b0;
    repeat (2) tick();

    btn = 1'b1;
    repeat (12) tick();
    clr();
    a7 = 32'd1; a0 = 32'hBEEF; ecall = 1'b1;
    exp_disp = 32'hBEEF;
    repeat (30) tick();
    chk("held_no_fin", runs, 0);
    chk("held_waiting", {31'd0, waiting}, 32'd1);
    btn = 1'b0;
    repeat (10) tick();
    press();
    chk("held_then_new", runs, 1);
    repeat (10) tick();
    chk("rearm_single", runs, 1);
    ecall = 1'b0;
    repeat (2) tick();

    do_call(32'd7, 32'hDEAD, 16'h0, 1'b0);

    clr();
    a7 = 32'd10; ecall = 1'b1;
    tick();
    chk("halted", {31'd0, halted}, 32'd1);
    press();
    ecall = 1'b0;
    repeat (1000) tick();
    chk("halt_no_fin", fin_cyc, 0);
    chk("halt_stays", {31'd0, halted}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
